// File: rtl/adc_capture_sched.sv
// Round-robin capture scheduler: moves I2S ADC receiver words into a ping-pong
// sample BRAM, handshakes each receiver with an ack pulse and swaps banks per frame.
module adc_capture_sched #(
  parameter int N_CH        = 4,
  parameter int FRAME_LEN   = 512,
  parameter int ACK_HOLD    = 2,
  parameter int REL_TIMEOUT = 64
) (
  input  logic                                       sck,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       stop,
  output logic                                       adc_start,
  input  logic [N_CH-1:0]                            ready,
  input  logic [32*N_CH-1:0]                         adc_data,
  output logic [N_CH-1:0]                            ack,
  input  logic                                       fft_busy,
  output logic                                       bram_we,
  output logic [$clog2(FRAME_LEN)+$clog2(N_CH):0]    bram_addr,
  output logic [31:0]                                bram_din,
  output logic                                       frame_done,
  output logic                                       frame_bank,
  output logic                                       busy,
  output logic                                       overrun,
  output logic                                       ack_err
);

  localparam int CH_W    = $clog2(N_CH);
  localparam int IDX_W   = $clog2(FRAME_LEN);
  localparam int CNT_MAX = (ACK_HOLD > REL_TIMEOUT) ? ACK_HOLD : REL_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ADDR_W  = 1 + IDX_W + CH_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SCAN, S_WRITE, S_HOLD, S_RELEASE, S_CHECK, S_SWAP
  } state_t;

  state_t            r_state, w_next;
  logic              r_bank;
  logic [IDX_W:0]    r_idx [N_CH];
  logic [CH_W-1:0]   r_last, r_gnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_stop_pend;

  logic              r_adc_start, r_bram_we, r_frame_done, r_frame_bank;
  logic              r_busy, r_overrun, r_ack_err;
  logic [N_CH-1:0]   r_ack;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [31:0]       r_bram_din;

  logic [N_CH-1:0]   w_elig;
  logic              w_all_full, w_found, w_stop, w_rel_tmo;
  logic [CH_W-1:0]   w_pick, w_cand;

  // A channel is full once its index reaches FRAME_LEN, i.e. the top bit is set.
  always_comb begin
    w_elig     = '0;
    w_all_full = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      w_elig[c]  = ready[c] & ~r_idx[c][IDX_W];
      w_all_full = w_all_full & r_idx[c][IDX_W];
    end
  end

  // Search starts just after the last grant; the N_CH-th step wraps back onto it.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      w_cand = r_last + CH_W'(i);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_stop    = r_stop_pend | stop;
  assign w_rel_tmo = (r_state == S_RELEASE) && ready[r_gnt] &&
                     (r_cnt == CNT_W'(REL_TIMEOUT - 1));

  // NOTE: every always_comb output is given a default first, so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_ARM;
      S_ARM:     w_next = S_SCAN;
      S_SCAN:    if (w_stop) w_next = S_IDLE;
                 else if (w_found) w_next = S_WRITE;
      S_WRITE:   w_next = (ACK_HOLD > 1) ? S_HOLD : S_RELEASE;
      S_HOLD:    if (r_cnt == CNT_W'(ACK_HOLD - 2)) w_next = S_RELEASE;
      S_RELEASE: if (!ready[r_gnt] || w_rel_tmo) w_next = S_CHECK;
      S_CHECK:   if (w_all_full) w_next = S_SWAP;
                 else w_next = w_stop ? S_IDLE : S_SCAN;
      S_SWAP:    w_next = w_stop ? S_IDLE : S_SCAN;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples the same pre-edge values.
  always_ff @(posedge sck) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bank       <= 1'b0;
      r_last       <= CH_W'(N_CH - 1);
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_stop_pend  <= 1'b0;
      for (int c = 0; c < N_CH; c++) r_idx[c] <= '0;
      r_adc_start  <= 1'b0;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_din   <= '0;
      r_ack        <= '0;
      r_frame_done <= 1'b0;
      r_frame_bank <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_ack_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;

      // In IDLE only a start can leave, so a simultaneous stop is what gets latched.
      if (w_next == S_IDLE)      r_stop_pend <= 1'b0;
      else if (r_state == S_IDLE) r_stop_pend <= stop;
      else if (stop)             r_stop_pend <= 1'b1;

      if (r_state == S_SCAN && w_next == S_WRITE) begin
        r_gnt         <= w_pick;
        r_last        <= w_pick;
        r_idx[w_pick] <= r_idx[w_pick] + 1'b1;
        r_bram_addr   <= {r_bank, r_idx[w_pick][IDX_W-1:0], w_pick};
        r_bram_din    <= {adc_data[32*w_pick+8 +: 24], 8'h00};
      end

      if (r_state == S_SWAP || (w_next == S_IDLE && r_state != S_IDLE))
        for (int c = 0; c < N_CH; c++) r_idx[c] <= '0;

      // A refused swap keeps the bank; the FFT still owns the other one.
      if (r_state == S_SWAP) begin
        if (fft_busy) r_overrun <= 1'b1;
        else          r_bank    <= ~r_bank;
      end
      if (w_rel_tmo) r_ack_err <= 1'b1;

      r_adc_start  <= (w_next == S_ARM);
      r_bram_we    <= (w_next == S_WRITE);
      r_frame_done <= (w_next == S_SWAP);
      r_busy       <= (w_next != S_IDLE);
      if (w_next == S_SWAP) r_frame_bank <= r_bank;

      if (w_next == S_WRITE)     r_ack <= N_CH'(1) << w_pick;
      else if (w_next != S_HOLD) r_ack <= '0;
    end
  end

  assign adc_start  = r_adc_start;
  assign bram_we    = r_bram_we;
  assign bram_addr  = r_bram_addr;
  assign bram_din   = r_bram_din;
  assign ack        = r_ack;
  assign frame_done = r_frame_done;
  assign frame_bank = r_frame_bank;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign ack_err    = r_ack_err;

endmodule

// File: tb/tb_adc_capture_sched.sv
// Directed bench for adc_capture_sched with simple I2S receiver models that
// drop ready after ack falls and optionally re-arm with a new word.
module tb_adc_capture_sched;

  localparam int N_CH        = 2;
  localparam int FRAME_LEN   = 4;
  localparam int ACK_HOLD    = 2;
  localparam int REL_TIMEOUT = 8;

  logic        sck = 1'b0;
  logic        rst, start, stop, fft_busy;
  logic        adc_start, bram_we, frame_done, frame_bank, busy, overrun, ack_err;
  logic [1:0]  ready, ack;
  logic [63:0] adc_data;
  logic [3:0]  bram_addr;
  logic [31:0] bram_din;

  always #5 sck = ~sck;

  adc_capture_sched #(
    .N_CH(N_CH), .FRAME_LEN(FRAME_LEN), .ACK_HOLD(ACK_HOLD), .REL_TIMEOUT(REL_TIMEOUT)
  ) dut (
    .sck(sck), .rst(rst), .start(start), .stop(stop), .adc_start(adc_start),
    .ready(ready), .adc_data(adc_data), .ack(ack), .fft_busy(fft_busy),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .frame_done(frame_done), .frame_bank(frame_bank), .busy(busy),
    .overrun(overrun), .ack_err(ack_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [3:0]  wr_addr_q[$];
  logic [31:0] wr_din_q[$];
  int   cyc = 0, frames = 0, err_cyc = 0, ack_multi = 0, we_bad = 0;
  int   ack_run[2], ack_len[2], fall_cyc[2];
  logic fb = 1'b0, ack_err_q = 1'b0;

  always @(negedge sck) begin
    cyc++;
    if (bram_we) begin
      wr_addr_q.push_back(bram_addr);
      wr_din_q.push_back(bram_din);
    end
    if (frame_done) begin
      frames++;
      fb = frame_bank;
    end
    if ($countones(ack) > 1) ack_multi++;
    if (bram_we && ack == 2'b00) we_bad++;
    for (int c = 0; c < 2; c++) begin
      if (ack[c]) ack_run[c]++;
      else if (ack_run[c] != 0) begin
        ack_len[c]  = ack_run[c];
        ack_run[c]  = 0;
        fall_cyc[c] = cyc;
      end
    end
    if (ack_err && !ack_err_q) err_cyc = cyc;
    ack_err_q = ack_err;
  end

  // Receiver models: drop ready once ack has fallen, re-arm a cycle later if auto.
  logic [1:0] rx_auto, rx_stuck, rearm, ack_seen;

  task automatic cycle();
    @(negedge sck);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (ack_seen[c] && !ack[c]) begin
        if (!rx_stuck[c]) begin
          ready[c] = 1'b0;
          rearm[c] = rx_auto[c];
        end
      end else if (rearm[c]) begin
        ready[c] = 1'b1;
        rearm[c] = 1'b0;
      end
    end
    ack_seen = ack;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; fft_busy = 1'b0; ready = 2'b00;
    rx_auto = 2'b00; rx_stuck = 2'b00; rearm = 2'b00; ack_seen = 2'b00;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    wr_addr_q.delete();
    wr_din_q.delete();
    frames = 0; err_cyc = 0;
    for (int c = 0; c < 2; c++) begin
      ack_len[c] = 0; ack_run[c] = 0; fall_cyc[c] = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    int k = 0;
    while (wr_addr_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, wr_addr_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      cycle();
      k++;
    end
    check("stop_idle_busy", busy, 0);
  endtask

  initial begin
    adc_data = {32'h11223344, 32'hAABBCC11};

    // Reset and arming.
    do_reset();
    check("rst_outs", {adc_start, ack, bram_we, frame_done, frame_bank, busy, overrun, ack_err}, 0);
    check("rst_addr", bram_addr, 0);
    start = 1'b1;
    cycle();
    check("adc_start_pulse", adc_start, 1);
    check("busy_armed", busy, 1);
    start = 1'b0;
    cycle();
    check("adc_start_one_cycle", adc_start, 0);
    repeat (5) cycle();
    check("no_we_without_ready", wr_addr_q.size(), 0);

    // Two single words, ch0 then ch1.
    ready = 2'b11;
    wait_wr(2, 40, "two_writes");
    repeat (6) cycle();
    check("wr0_addr", wr_addr_q[0], 0);
    check("wr0_din", wr_din_q[0], 32'hAABBCC00);
    check("wr1_addr", wr_addr_q[1], 1);
    check("wr1_din", wr_din_q[1], 32'h11223300);
    check("ack0_len", ack_len[0], 2);
    check("ack1_len", ack_len[1], 2);
    check("no_extra_writes", wr_addr_q.size(), 2);

    // Continuous frame, then a stop during HOLD of the first bank-1 write.
    do_reset();
    pulse_start();
    ready = 2'b11; rx_auto = 2'b11;
    wait_wr(9, 300, "frame_writes");
    for (int i = 0; i < 8; i++) check($sformatf("frame_addr%0d", i), wr_addr_q[i], i);
    check("frame_done_count", frames, 1);
    check("frame_bank0", fb, 0);
    check("bank1_first_addr", wr_addr_q[8], 8);
    rx_auto = 2'b00;
    cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    wait_idle(30);
    check("stop_ack_len", ack_len[0], 2);
    check("stop_ack_low", ack, 0);
    check("stop_write_count", wr_addr_q.size(), 9);
    ready = 2'b11;
    pulse_start();
    wait_wr(11, 60, "resume_writes");
    check("resume_ch1_addr", wr_addr_q[9], 9);
    check("resume_ch0_idx0", wr_addr_q[10], 8);

    // Frame end with the FFT still busy.
    do_reset();
    fft_busy = 1'b1;
    ready = 2'b11; rx_auto = 2'b11;
    pulse_start();
    wait_wr(9, 300, "ovr_writes");
    check("ovr_frame_done", frames, 1);
    check("ovr_frame_bank", fb, 0);
    check("ovr_set", overrun, 1);
    check("ovr_restart_addr", wr_addr_q[8], 0);
    fft_busy = 1'b0;
    repeat (20) cycle();
    check("ovr_sticky", overrun, 1);

    // ch0 receiver never drops ready.
    do_reset();
    check("ovr_cleared_by_rst", overrun, 0);
    check("ack_err_rst", ack_err, 0);
    rx_stuck = 2'b01;
    ready = 2'b11;
    pulse_start();
    wait_wr(2, 60, "err_writes");
    check("err_first_ch0", wr_addr_q[0], 0);
    check("err_next_ch1", wr_addr_q[1], 1);
    check("ack_err_set", ack_err, 1);
    check("ack_err_delay", err_cyc - fall_cyc[0], 8);

    check("ack_onehot", ack_multi, 0);
    check("we_with_ack", we_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/adc_capture_sched.md
Name: adc_capture_sched

Overview:
- Round-robin scheduler that services N_CH I2S ADC receiver channels. Each channel presents a 32-bit word and a ready flag.
- For each ready channel it writes the word into a ping-pong sample BRAM that feeds the FFT, then acknowledges the channel with a flag_in high-then-low pulse so the receiver re-arms.
- Counts samples per channel, signals a completed frame to the FFT controller, and swaps banks.

Parameters:
- N_CH, 4, number of ADC channels; power of two, ≥2.
- FRAME_LEN, 512, samples per channel per frame; power of two.
- ACK_HOLD, 2, cycles ack stays high; ≥1.
- REL_TIMEOUT, 64, max cycles to wait for ready to drop after ack release.

Ports:
- sck  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: begin capture.
- stop  in  1  one-cycle pulse: stop after the current transaction.
- adc_start  out  1  one-cycle pulse to the receivers' start inputs.
- ready  in  N_CH  per-channel word-ready (receiver flag_out).
- adc_data  in  32*N_CH  channel c word at [32c+31:32c]; sample in [31:8].
- ack  out  N_CH  per-channel acknowledge (receiver flag_in); the receiver clears ready on ack's falling edge.
- fft_busy  in  1  FFT is still reading the bank that would be filled next.
- bram_we  out  1  write strobe.
- bram_addr  out  1+log2(FRAME_LEN)+log2(N_CH)  {bank, sample_idx, ch}.
- bram_din  out  32  {adc_data[31:8], 8'h00}.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_bank  out  1  bank just completed; valid with frame_done, held until the next frame.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky; a bank swap was refused because fft_busy was high.
- ack_err  out  1  sticky; ready did not drop within REL_TIMEOUT.

Behaviour:
- All outputs are registered. On rst:
  - Outputs 0.
  - bank=0, all sample_idx=0, last_grant=N_CH-1, state=IDLE.
  - rst mid-transaction drops ack the same edge; the receiver treats that falling edge as an acknowledge, which is acceptable.
- IDLE: start → ARM. stop is ignored.
- ARM: adc_start=1 for one cycle → SCAN.
- SCAN:
  - Eligible channels: ready[c]=1 and sample_idx[c]<FRAME_LEN.
  - Grant goes to the first eligible channel searching from last_grant+1 mod N_CH.
  - On a grant, latch g, latch adc_data word g and the address → WRITE.
  - If none is eligible, stay in SCAN.
  - A pending stop → IDLE (checked before granting).
- WRITE (1 cycle):
  - bram_we=1; bram_addr={bank, sample_idx[g], g}; ack[g]=1.
  - sample_idx[g]++ and last_grant=g.
  - → HOLD if ACK_HOLD>1, else RELEASE.
- HOLD: ack[g]=1 for ACK_HOLD-1 further cycles → RELEASE.
- RELEASE:
  - ack[g]=0 and a timeout counter starts.
  - ready[g]=0 → CHECK.
  - Counter reaches REL_TIMEOUT → set ack_err → CHECK.
- CHECK:
  - If every sample_idx==FRAME_LEN → SWAP. Otherwise → SCAN, or IDLE if stop is pending.
- SWAP (1 cycle):
  - frame_done=1 and frame_bank=bank.
  - fft_busy=0: bank toggles.
  - fft_busy=1: bank is unchanged (it is overwritten next frame) and overrun is set.
  - All sample_idx clear.
  - → SCAN, or IDLE if stop is pending.
- Channels that are full are masked. Their ready stays high and the receiver idles until the swap.
- stop is latched as pending in any state and cleared on entry to IDLE. start is ignored outside IDLE.
- A start and stop in the same cycle in IDLE: start wins and pending stop is set, so the block arms and then returns to IDLE from SCAN.
- bank persists across stop/start; sample_idx clears on entry to IDLE.
- Exactly one ack bit is ever high. bram_we is never high outside WRITE.

Test Plan (N_CH=2, FRAME_LEN=4, ACK_HOLD=2, REL_TIMEOUT=8):
- rst, then start: adc_start pulses exactly one cycle after start. busy=1. No bram_we while ready=0.
- ready=2'b11 with words 0xAABBCC11 and 0x11223344; each receiver model drops ready 1 cycle after ack falls:
  - First write is ch0 at addr 0, din 0xAABBCC00.
  - Second write is ch1 at addr 1, din 0x11223300.
  - ack high exactly 2 cycles each.
- Continuous ready on both channels for 8 words:
  - Addresses are 0,1,2,3,4,5,6,7.
  - frame_done pulses once with frame_bank=0.
  - The next write goes to addr 8 (bank 1).
- fft_busy=1 at the frame end: overrun=1 and frame_done still pulses. Next frame writes restart at addr 0. overrun stays 1 until rst.
- ready[0] held high after ack falls: ack_err=1 after 8 cycles. The scheduler resumes and ch1 is serviced next.
- stop during HOLD: the write completes, ack releases, the block returns to IDLE with busy=0. A later start resumes at sample_idx 0 in the same bank.
